// File: rtl/lbus_pkg.sv
// Shared types and constants for the local-bus fabric.
package lbus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RD_WAIT = ST_RD,
        WR_WAIT = ST_WR
    } lbus_state_t;

    localparam int          CNT_W        = 8;
    localparam int          DEF_TIMEOUT  = 16;
    localparam logic [31:0] DEF_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/lbus_addr_decode.sv
// Base/mask window compare across all slaves; lowest index wins on overlap.
module lbus_addr_decode
    import lbus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {3{32'hF000_0000}},
    localparam int                      IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic [31:0]   offset
);

    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = addr & ~SLAVE_MASK[31:0];
        // Walk downward so the lowest matching index is the one left standing
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit    = 1'b1;
                idx    = IW'(i);
                offset = addr & ~SLAVE_MASK[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/lbus_fabric.sv
// Single-master, N-slave local-bus fabric with wait states,
// per-access timeout and sticky error capture.
module lbus_fabric
    import lbus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {3{32'hF000_0000}},
    parameter logic [NUM_SLAVES-1:0]    FIXED_LAT  = 3'b001,
    parameter int                       TIMEOUT    = DEF_TIMEOUT,
    parameter logic [31:0]              ERR_DATA   = DEF_ERR_DATA
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    input  logic [3:0]                 m_wmask,
    input  logic                       m_rstrb,
    output logic [31:0]                m_rdata,
    output logic                       m_rbusy,
    output logic                       m_wbusy,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    output logic [NUM_SLAVES-1:0]      s_wen,
    output logic [NUM_SLAVES-1:0]      s_ren,
    input  logic [NUM_SLAVES-1:0]      s_wready,
    input  logic [NUM_SLAVES-1:0]      s_rvalid,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    output logic                       err,
    output logic [31:0]                err_addr,
    input  logic                       err_clr
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    lbus_state_t     state_q, state_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [31:0]     offs_q, offs_d;
    logic [31:0]     maddr_q, maddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            force_q, force_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [NUM_SLAVES-1:0] ren_q;
    logic            err_q;
    logic [31:0]     err_addr_q;
    logic            err_set;
    logic [31:0]     err_at;

    logic            dec_hit;
    logic [IW-1:0]   dec_idx;
    logic [31:0]     dec_offs;

    logic [NUM_SLAVES-1:0] rvalid_eff;
    logic [NUM_SLAVES-1:0] wready_eff;
    logic                  tmo;

    lbus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr   (m_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_offs)
    );

    // Fixed-latency slaves answer reads one cycle after ren and never stall writes
    assign rvalid_eff = (FIXED_LAT & ren_q) | (~FIXED_LAT & s_rvalid);
    assign wready_eff = FIXED_LAT | s_wready;
    assign tmo        = (cnt_q == CNT_W'(TIMEOUT - 1));

    assign m_rdata  = rdata_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        offs_d  = offs_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        force_d = 1'b0;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_set = 1'b0;
        err_at  = maddr_q;
        s_wen   = '0;
        s_ren   = '0;
        s_addr  = offs_q;
        s_wdata = wdata_q;
        s_wstrb = wstrb_q;
        m_rbusy = 1'b0;
        m_wbusy = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_addr  = dec_offs;
                s_wdata = m_wdata;
                s_wstrb = m_wmask;
                cnt_d   = '0;
                if (!rst && m_wmask != 4'h0) begin
                    if (dec_hit) begin
                        s_wen[dec_idx] = 1'b1;
                        sel_d   = dec_idx;
                        offs_d  = dec_offs;
                        maddr_d = m_addr;
                        wdata_d = m_wdata;
                        wstrb_d = m_wmask;
                        if (!wready_eff[dec_idx]) state_d = WR_WAIT;
                    end else begin
                        err_set = 1'b1;
                        err_at  = m_addr;
                    end
                end else if (!rst && m_rstrb) begin
                    sel_d   = dec_idx;
                    offs_d  = dec_offs;
                    maddr_d = m_addr;
                    wstrb_d = '0;
                    state_d = RD_WAIT;
                    if (dec_hit) begin
                        s_ren[dec_idx] = 1'b1;
                    end else begin
                        rdata_d = ERR_DATA;
                        force_d = 1'b1;
                        err_set = 1'b1;
                        err_at  = m_addr;
                    end
                end
            end
            RD_WAIT: begin
                m_rbusy = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (force_q) begin
                    state_d = IDLE;
                end else if (rvalid_eff[sel_q]) begin
                    rdata_d = s_rdata[32*sel_q +: 32];
                    state_d = IDLE;
                end else if (tmo) begin
                    rdata_d = ERR_DATA;
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                m_wbusy      = 1'b1;
                s_wen[sel_q] = 1'b1;
                cnt_d        = cnt_q + 1'b1;
                if (wready_eff[sel_q]) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            offs_q     <= '0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            force_q    <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            ren_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            offs_q  <= offs_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            force_q <= force_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ren_q   <= s_ren;
            // Clear beats a coincident error; only the first error is recorded
            if (err_clr) begin
                err_q      <= 1'b0;
                err_addr_q <= '0;
            end else if (err_set && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= err_at;
            end
        end
    end

endmodule

// File: tb/tb_lbus_fabric.sv
// Scoreboard bench: stimulus queues expected completions, a negedge
// monitor pops them as reads/writes finish on the bus.
module tb_lbus_fabric;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;
    logic        m_rstrb;
    logic [31:0] m_rdata;
    logic        m_rbusy, m_wbusy;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_wen, s_ren, s_wready, s_rvalid;
    logic [95:0] s_rdata;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clr;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        int          busy;
        int          wen;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    lbus_fabric dut (
        .clk      (clk),
        .rst      (rst),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wmask  (m_wmask),
        .m_rstrb  (m_rstrb),
        .m_rdata  (m_rdata),
        .m_rbusy  (m_rbusy),
        .m_wbusy  (m_wbusy),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wen    (s_wen),
        .s_ren    (s_ren),
        .s_wready (s_wready),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata),
        .err      (err),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit w, input logic [31:0] d, input int b, input int e);
        exp_t x;
        x.is_wr = w;
        x.data  = d;
        x.busy  = b;
        x.wen   = e;
        q.push_back(x);
    endtask

    task automatic idle_bus();
        m_wmask  = 4'h0;
        m_rstrb  = 1'b0;
        s_rvalid = 3'b000;
        s_wready = 3'b000;
        err_clr  = 1'b0;
    endtask

    // Monitor: counts busy/enable runs and scores each completed transfer
    initial begin
        int   rb_cnt = 0;
        int   wb_cnt = 0;
        int   we_cnt = 0;
        bit   prev_rb = 0;
        bit   prev_we = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (m_rbusy) begin
                    rb_cnt++;
                end else if (prev_rb) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_unexpected: got read completion expected none");
                    end else begin
                        e = q.pop_front();
                        check("rd_kind", 32'(e.is_wr), 32'd0);
                        check("rd_data", m_rdata, e.data);
                        check("rd_busy_cycles", 32'(rb_cnt), 32'(e.busy));
                    end
                    rb_cnt = 0;
                end
                if (|s_wen) begin
                    we_cnt++;
                    if (m_wbusy) wb_cnt++;
                end else if (prev_we) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: got write completion expected none");
                    end else begin
                        e = q.pop_front();
                        check("wr_kind", 32'(e.is_wr), 32'd1);
                        check("wr_wen_cycles", 32'(we_cnt), 32'(e.wen));
                        check("wr_busy_cycles", 32'(wb_cnt), 32'(e.busy));
                    end
                    we_cnt = 0;
                    wb_cnt = 0;
                end
                prev_rb = m_rbusy;
                prev_we = |s_wen;
            end
        end
    end

    initial begin
        rst     = 1'b1;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        idle_bus();
        tick(3);
        rst = 1'b0;
        #1;
        check("rst_rbusy", 32'(m_rbusy), 32'd0);
        check("rst_wbusy", 32'(m_wbusy), 32'd0);
        check("rst_wen", 32'(s_wen), 32'd0);
        check("rst_ren", 32'(s_ren), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_rdata", m_rdata, 32'd0);
        mon_en = 1;
        tick();

        // Zero-wait read of slave 1
        m_addr  = 32'h1000_0004;
        m_rstrb = 1'b1;
        #1;
        check("rd1_ren", 32'(s_ren), 32'b010);
        check("rd1_saddr", s_addr, 32'h4);
        push(0, 32'hA5A5_0001, 1, 0);
        tick();
        m_rstrb  = 1'b0;
        s_rvalid = 3'b010;
        s_rdata[63:32] = 32'hA5A5_0001;
        #1;
        check("rd1_ren_once", 32'(s_ren), 32'b000);
        tick();
        idle_bus();
        tick(2);

        // Stray rvalid from an unselected slave must not complete the read
        m_addr  = 32'h1000_0020;
        m_rstrb = 1'b1;
        push(0, 32'h5555_AAAA, 2, 0);
        tick();
        m_rstrb  = 1'b0;
        s_rvalid = 3'b100;
        s_rdata[95:64] = 32'hDEAD_BEEF;
        tick();
        s_rvalid = 3'b010;
        s_rdata[63:32] = 32'h5555_AAAA;
        tick();
        idle_bus();
        tick(2);

        // Write to slave 2 with three wait states
        m_addr  = 32'h2000_0008;
        m_wdata = 32'hCAFE_F00D;
        m_wmask = 4'hF;
        #1;
        check("wr_wen0", 32'(s_wen), 32'b100);
        check("wr_saddr", s_addr, 32'h8);
        push(1, 32'h0, 3, 4);
        tick();
        m_wmask = 4'h0;
        m_wdata = 32'h0;
        m_addr  = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) s_wready = 3'b100;
            #1;
            check("wr_held_wen", 32'(s_wen), 32'b100);
            check("wr_held_wdata", s_wdata, 32'hCAFE_F00D);
            check("wr_held_addr", s_addr, 32'h8);
            check("wr_held_strb", 32'(s_wstrb), 32'hF);
            tick();
        end
        idle_bus();
        tick(2);

        // Read that times out on slave 1
        m_addr  = 32'h1000_0100;
        m_rstrb = 1'b1;
        push(0, 32'h0, 16, 0);
        tick();
        m_rstrb = 1'b0;
        tick(18);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_err_addr", err_addr, 32'h1000_0100);

        // Fixed-latency read of slave 0
        s_rdata[31:0] = 32'h0000_1234;
        m_addr  = 32'h0000_0010;
        m_rstrb = 1'b1;
        #1;
        check("fl_ren", 32'(s_ren), 32'b001);
        check("fl_saddr", s_addr, 32'h10);
        push(0, 32'h0000_1234, 1, 0);
        tick();
        idle_bus();
        tick(3);

        // Fixed-latency write: never stalls
        m_addr  = 32'h0000_0020;
        m_wdata = 32'h1111_2222;
        m_wmask = 4'h1;
        #1;
        check("flw_wbusy", 32'(m_wbusy), 32'd0);
        push(1, 32'h0, 0, 1);
        tick();
        idle_bus();
        tick(2);

        // Unmapped read with err already set: err_addr keeps the first error
        m_addr  = 32'h5000_0000;
        m_rstrb = 1'b1;
        #1;
        check("um_ren", 32'(s_ren), 32'b000);
        push(0, 32'h0, 1, 0);
        tick();
        idle_bus();
        tick(2);
        check("um_err_keep", err_addr, 32'h1000_0100);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        check("clr_err_addr", err_addr, 32'd0);

        // Clear coinciding with a new unmapped write
        m_addr  = 32'h6000_0000;
        m_wmask = 4'hF;
        err_clr = 1'b1;
        #1;
        check("umw_wen", 32'(s_wen), 32'b000);
        tick();
        idle_bus();
        #1;
        check("clr_wins", 32'(err), 32'd0);

        m_addr  = 32'h5000_0000;
        m_rstrb = 1'b1;
        push(0, 32'h0, 1, 0);
        tick();
        idle_bus();
        tick(2);
        check("um_err", 32'(err), 32'd1);
        check("um_err_addr", err_addr, 32'h5000_0000);

        // Reset while stalled in a write
        m_addr  = 32'h2000_0000;
        m_wdata = 32'h0BAD_0BAD;
        m_wmask = 4'h3;
        push(1, 32'h0, 1, 2);
        tick();
        m_wmask = 4'h0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstw_wen", 32'(s_wen), 32'b000);
        check("rstw_wbusy", 32'(m_wbusy), 32'd0);
        check("rstw_err", 32'(err), 32'd0);
        tick(2);

        // Simultaneous write and read strobe: write wins
        m_addr   = 32'h1000_0000;
        m_wdata  = 32'h7777_8888;
        m_wmask  = 4'h1;
        m_rstrb  = 1'b1;
        s_wready = 3'b010;
        #1;
        check("both_wen", 32'(s_wen), 32'b010);
        check("both_ren", 32'(s_ren), 32'b000);
        push(1, 32'h0, 0, 1);
        tick();
        idle_bus();
        #1;
        check("both_no_rbusy", 32'(m_rbusy), 32'd0);
        tick(3);

        check("sb_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
